// File: rtl/cache_lfsr_pkg.sv
// Shared helpers for the cache victim-way selector.
// Holds the LFSR width derivation and the maximal-length tap table.
// Pure constants and constant functions; no logic, no timing.
package cache_lfsr_pkg;

  localparam int MAX_LFSR_W = 10;

  // LFSR is two bits wider than the way index so short runs of
  // identical indices do not lock the selector onto one way.
  function automatic int lfsr_width(input int numways);
    return $clog2(numways) + 2;
  endfunction

  // Legal way counts: power of two from 2 to 256.
  function automatic bit numways_ok(input int numways);
    return (numways >= 2) && (numways <= 256) && ((numways & (numways - 1)) == 0);
  endfunction

  // Tap mask for an n-bit Fibonacci LFSR; bit (t-1) set for tap t.
  // Every entry gives period 2^n-1.
  function automatic logic [MAX_LFSR_W-1:0] taps(input int n);
    logic [MAX_LFSR_W-1:0] m;
    case (n)
      3:       m = 10'b00_0000_0110;  // {3,2}
      4:       m = 10'b00_0000_1100;  // {4,3}
      5:       m = 10'b00_0001_0100;  // {5,3}
      6:       m = 10'b00_0011_0000;  // {6,5}
      7:       m = 10'b00_0110_0000;  // {7,6}
      8:       m = 10'b00_1011_1000;  // {8,6,5,4}
      9:       m = 10'b01_0001_0000;  // {9,5}
      10:      m = 10'b10_0100_0000;  // {10,7}
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cache_lfsr_first_invalid_way.sv
// Picks the lowest-indexed set bit of the invalid-way vector, one-hot.
// Latency: purely combinational.
// Backpressure: none; no handshake, output always reflects the input.
module cache_lfsr_first_invalid_way #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] invalid,
  output logic [WIDTH-1:0] first_onehot,
  output logic             any_invalid
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // x & -x isolates the lowest set bit; zero when nothing is invalid.
  assign first_onehot = invalid & (~invalid + ONE);
  assign any_invalid  = |invalid;

endmodule

// File: rtl/cache_lfsr.sv
// Victim-way selector: lowest invalid way, else an LFSR-chosen way, one-hot.
// Latency: VictimWay combinational from ValidWay; LFSR advance visible next cycle.
// Backpressure: none; FlushStage suppresses the advance, state otherwise holds.
module cache_lfsr
  import cache_lfsr_pkg::*;
#(
  parameter int NUMWAYS = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic               LFSRWriteEn,
  output logic [NUMWAYS-1:0] VictimWay
);

  localparam int LOGW = $clog2(NUMWAYS);
  localparam int N    = lfsr_width(NUMWAYS);
  localparam logic [MAX_LFSR_W-1:0] TAP_FULL = taps(N);

  generate
    if (!numways_ok(NUMWAYS)) begin : g_bad_numways
      $error("cache_lfsr: NUMWAYS must be a power of two between 2 and 256");
    end
  endgenerate

  logic [N-1:0]       curr_random;
  logic               fb;
  logic               advance;
  logic [LOGW-1:0]    rand_idx;
  logic [NUMWAYS-1:0] rand_onehot;
  logic [NUMWAYS-1:0] invalid_ways;
  logic [NUMWAYS-1:0] first_onehot;
  logic               any_invalid;

  // Only a committed fill moves the sequence; a flushed one must not.
  assign advance = LFSRWriteEn & ~FlushStage;
  assign fb      = ^(curr_random & TAP_FULL[N-1:0]);

  // State register: seed 1 keeps the LFSR out of the all-zero lockup state.
  always_ff @(posedge clock) begin
    if (reset) begin
      curr_random <= N'(1);
    end else if (advance) begin
      curr_random <= {curr_random[N-2:0], fb};
    end
  end

  assign rand_idx = curr_random[LOGW-1:0];

  // Binary-to-one-hot decode of the random way index.
  always_comb begin
    rand_onehot           = '0;
    rand_onehot[rand_idx] = 1'b1;
  end

  assign invalid_ways = ~ValidWay;

  cache_lfsr_first_invalid_way #(
    .WIDTH (NUMWAYS)
  ) u_first_invalid_way (
    .invalid      (invalid_ways),
    .first_onehot (first_onehot),
    .any_invalid  (any_invalid)
  );

  // Filling an empty way never evicts anything, so invalid ways take priority.
  assign VictimWay = any_invalid ? first_onehot : rand_onehot;

endmodule

// File: tb/tb_cache_lfsr.sv
// Directed bench for cache_lfsr at NUMWAYS=128, plus a period sweep at 2/4/8/256.
// Latency: checks sampled on the falling edge, inputs driven there too.
// Backpressure: none; fixed cycle loops with a watchdog.
module tb_cache_lfsr;

  localparam int NW = 128;

  logic          clock = 1'b0;
  logic          reset, flush_stage, lfsr_wen;
  logic [NW-1:0] valid_way, victim_way;

  logic          sw_reset, sw_wen, sw_flush;
  logic [1:0]    vw2, vic2;
  logic [3:0]    vw4, vic4;
  logic [7:0]    vw8, vic8;
  logic [255:0]  vw256, vic256;

  int            n_checks = 0;
  int            n_fail   = 0;

  logic [9:0]    m_state;
  logic [9:0]    sm [4];
  int            sw_n [4] = '{3, 4, 5, 10};

  cache_lfsr #(.NUMWAYS(NW)) dut (
    .clock(clock), .reset(reset), .FlushStage(flush_stage),
    .ValidWay(valid_way), .LFSRWriteEn(lfsr_wen), .VictimWay(victim_way));

  cache_lfsr #(.NUMWAYS(2)) dut2 (
    .clock(clock), .reset(sw_reset), .FlushStage(sw_flush),
    .ValidWay(vw2), .LFSRWriteEn(sw_wen), .VictimWay(vic2));

  cache_lfsr #(.NUMWAYS(4)) dut4 (
    .clock(clock), .reset(sw_reset), .FlushStage(sw_flush),
    .ValidWay(vw4), .LFSRWriteEn(sw_wen), .VictimWay(vic4));

  cache_lfsr #(.NUMWAYS(8)) dut8 (
    .clock(clock), .reset(sw_reset), .FlushStage(sw_flush),
    .ValidWay(vw8), .LFSRWriteEn(sw_wen), .VictimWay(vic8));

  cache_lfsr #(.NUMWAYS(256)) dut256 (
    .clock(clock), .reset(sw_reset), .FlushStage(sw_flush),
    .ValidWay(vw256), .LFSRWriteEn(sw_wen), .VictimWay(vic256));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference LFSR step, taps written out from the tap table.
  function automatic logic [9:0] lfsr_next(input logic [9:0] s, input int n);
    logic fb;
    case (n)
      3:       fb = s[2] ^ s[1];
      4:       fb = s[3] ^ s[2];
      5:       fb = s[4] ^ s[2];
      6:       fb = s[5] ^ s[4];
      7:       fb = s[6] ^ s[5];
      8:       fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      9:       fb = s[8] ^ s[4];
      10:      fb = s[9] ^ s[6];
      default: fb = 1'b0;
    endcase
    return ((s << 1) | {9'b0, fb}) & ((10'd1 << n) - 10'd1);
  endfunction

  function automatic logic [NW-1:0] exp_victim(input logic [NW-1:0] v, input logic [9:0] st);
    logic [NW-1:0] r;
    bit            found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (!v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    if (!found) r[st[6:0]] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [NW-1:0] v);
    for (int i = 0; i < NW; i++) if (v[i] === 1'b1) return i;
    return 0;
  endfunction

  // One clock: update the reference models with the inputs seen at the edge.
  task automatic tick();
    @(posedge clock);
    if (reset) m_state = 10'd1;
    else if (lfsr_wen && !flush_stage) m_state = lfsr_next(m_state, 9);
    for (int k = 0; k < 4; k++) begin
      if (sw_reset) sm[k] = 10'd1;
      else if (sw_wen && !sw_flush) sm[k] = lfsr_next(sm[k], sw_n[k]);
    end
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            seq [6] = '{2, 4, 8, 16, 33, 66};
    bit            seen [512];
    logic [8:0]    rec;
    logic          p1, p2;
    int            idx, repeats;
    logic [NW-1:0] holes;

    m_state     = 10'd0;
    for (int k = 0; k < 4; k++) sm[k] = 10'd0;
    reset       = 1'b1;
    flush_stage = 1'b0;
    lfsr_wen    = 1'b0;
    valid_way   = '1;
    sw_reset    = 1'b1;
    sw_wen      = 1'b0;
    sw_flush    = 1'b0;
    vw2 = '1; vw4 = '1; vw8 = '1; vw256 = '1;

    // 1: reset with all ways valid, then hold without advancing.
    tick();
    lfsr_wen = 1'b1;
    tick();
    #1 check("reset_during", victim_way, 128'd1 << 1);
    reset    = 1'b0;
    lfsr_wen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_no_wen", victim_way, 128'd1 << 1);
    end

    // 2: six advances give indices 2,4,8,16,33,66.
    lfsr_wen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq_first6", victim_way, 128'd1 << seq[i]);
    end

    // 2b: full period; rebuild the 9-bit state from the observed indices.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p1 = 1'b0; p2 = 1'b0; repeats = 0;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      tick();
      check("period_seq", victim_way, exp_victim(valid_way, m_state));
      idx = idx_of(victim_way);
      rec = {p2, p1, idx[6:0]};
      p2  = p1;
      p1  = idx[6];
      if (i < 511) begin
        if (seen[rec]) repeats++;
        seen[rec] = 1'b1;
      end else begin
        check("period_wrap_state", rec, 9'd1);
      end
    end
    check("period_no_repeat", repeats, 0);
    check("period_wrap_victim", victim_way, 128'd1 << 1);

    // 3: invalid ways win regardless of LFSR state.
    holes     = '1;
    holes[5]  = 1'b0;
    holes[70] = 1'b0;
    valid_way = holes;
    for (int i = 0; i < 4; i++) begin
      #1 check("invalid_5_70", victim_way, 128'd1 << 5);
      tick();
    end
    valid_way[0] = 1'b0;
    #1 check("invalid_way0", victim_way, 128'd1);
    lfsr_wen  = 1'b0;
    valid_way = '1;

    // 4: flush suppresses the advance.
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    flush_stage = 1'b1;
    lfsr_wen    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_hold", victim_way, 128'd1 << 1);
    end
    flush_stage = 1'b0;
    tick();
    check("flush_release", victim_way, 128'd1 << 2);

    // 5: reset beats a simultaneous write enable.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("adv4", victim_way, 128'd1 << 16);
    reset = 1'b1;
    tick();
    check("reset_over_wen", victim_way, 128'd1 << 1);
    reset = 1'b0;

    // 5b: random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      valid_way = '1;
      if ($urandom_range(1) == 1)
        for (int j = 0; j < 3; j++) valid_way[$urandom_range(NW - 1)] = 1'b0;
      lfsr_wen    = ($urandom_range(1) == 1);
      flush_stage = ($urandom_range(3) == 0);
      reset       = ($urandom_range(63) == 0);
      #1;
      check("rand_victim", victim_way, exp_victim(valid_way, m_state));
      check("rand_onehot", 256'($onehot(victim_way)), 256'd1);
      tick();
    end
    reset       = 1'b0;
    lfsr_wen    = 1'b0;
    flush_stage = 1'b0;
    valid_way   = '1;

    // 6: parameter sweep, each width compared to its reference every cycle.
    tick();
    sw_reset = 1'b0;
    sw_wen   = 1'b1;
    for (int c = 0; c < 1024; c++) begin
      check("sweep_w2", vic2, 2'b01 << sm[0][0]);
      check("sweep_w4", vic4, 4'b0001 << sm[1][1:0]);
      check("sweep_w8", vic8, 8'b0000_0001 << sm[2][2:0]);
      check("sweep_w256", vic256, 256'd1 << sm[3][7:0]);
      tick();
    end
    sw_wen     = 1'b0;
    vw256[255] = 1'b0;
    #1 check("sweep_w256_top_invalid", vic256, 256'd1 << 255);
    vw2[0] = 1'b0;
    #1 check("sweep_w2_invalid0", vic2, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
